// File: rtl/hue_calc_sequencer.sv
// hue_calc_sequencer: streams a latched frame of note positions through one shared hue calculator and presents the hue array in slot order.
module hue_calc_sequencer #(
  parameter int W = 5,
  parameter int D = 11,
  parameter int NOTES = 12,
  parameter int BinsPerOctave = 24,
  parameter int HC_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [NOTES*(W+D)-1:0] notePositions_i,
  input  logic [NOTES-1:0]       noteValid_i,
  output logic [W+D-1:0]         hcNote_o,
  output logic                   hcStart_o,
  input  logic [D-2:0]           hcHue_i,
  input  logic                   hcValid_i,
  output logic [NOTES*(D-1)-1:0] hues_o,
  output logic [NOTES-1:0]       huesValid_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int PW = W + D;
  localparam int HW = D - 1;
  localparam int CW = $clog2(NOTES + 1);
  localparam logic [PW:0] LIMIT = (PW + 1)'(BinsPerOctave) << D;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pos_q [NOTES];
  logic [HW-1:0] hue_sh [NOTES];
  logic [HW-1:0] hue_nxt [NOTES];
  logic [NOTES*HW-1:0] hue_flat;
  logic [NOTES-1:0] mask_q, mask_in;
  logic [CW-1:0] issue_idx, write_idx, write_nxt;
  logic wr_en;
  if (HC_LAT < 1) begin : g_bad_lat
    $error("HC_LAT must be at least 1");
  end
  for (genvar g = 0; g < NOTES; g++) begin : g_slot
    assign mask_in[g] = noteValid_i[g] && ({1'b0, notePositions_i[g*PW +: PW]} < LIMIT);
    assign hue_flat[g*HW +: HW] = hue_nxt[g];
  end
  always_comb begin
    wr_en = hcValid_i && (state == ISSUE || state == DRAIN) && write_idx < CW'(NOTES);
    write_nxt = wr_en ? write_idx + CW'(1) : write_idx;
    hue_nxt = hue_sh;
    for (int k = 0; k < NOTES; k++)
      if (wr_en && write_idx == CW'(k)) hue_nxt[k] = mask_q[k] ? hcHue_i : '0;
    state_nxt = state == IDLE  ? (start_i ? ISSUE : IDLE) :
                state == ISSUE ? (issue_idx == CW'(NOTES - 1) ? DRAIN : ISSUE) :
                state == DRAIN ? (write_nxt == CW'(NOTES) ? DONE : DRAIN) : IDLE;
    hcStart_o = state == ISSUE;
    hcNote_o = (state == ISSUE && mask_q[issue_idx]) ? pos_q[issue_idx] : '0;
    busy_o = state != IDLE;
    done_o = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issue_idx <= '0;
      write_idx <= '0;
      mask_q <= '0;
      pos_q <= '{default: '0};
      hue_sh <= '{default: '0};
      hues_o <= '0;
      huesValid_o <= '0;
    end else begin
      state <= state_nxt;
      issue_idx <= state == ISSUE ? issue_idx + CW'(1) : '0;
      write_idx <= state == IDLE ? '0 : write_nxt;
      hue_sh <= hue_nxt;
      if (state == IDLE && start_i) begin
        mask_q <= mask_in;
        for (int k = 0; k < NOTES; k++) pos_q[k] <= notePositions_i[k*PW +: PW];
      end
      if (state == DRAIN && state_nxt == DONE) begin
        hues_o <= hue_flat;
        huesValid_o <= mask_q;
      end
    end
  end
endmodule
